// File: rtl/bus_fifo_if.sv
// rtl/bus_fifo_if.sv - bus-side signal bundle for bus_fifo (level present only with BUS_FIFO_LEVEL_EN)
interface bus_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic             clr;
  logic             wr;
  logic [WIDTH-1:0] in;
  logic             rd;
  logic             oe;
  wire  [WIDTH-1:0] out;
  logic             empty;
  logic             full;
  logic             ovf;

`ifdef BUS_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;

  modport master (output clr, wr, in, rd, oe, input out, empty, full, ovf, level);
  modport slave  (input clr, wr, in, rd, oe, output out, empty, full, ovf, level);
`else
  modport master (output clr, wr, in, rd, oe, input out, empty, full, ovf);
  modport slave  (input clr, wr, in, rd, oe, output out, empty, full, ovf);
`endif
endinterface

// File: rtl/bus_fifo.sv
// rtl/bus_fifo.sv - synchronous bus capture/replay FIFO with tristate output
// Optional occupancy output enabled by defining BUS_FIFO_LEVEL_EN.
module bus_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  bus_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             empty_q;
  logic             full_q;
  logic             ovf_q;
  logic             do_wr;
  logic             do_rd;

  // A pop on a full FIFO frees the slot, so a concurrent write is still taken.
  always_comb begin
    do_rd      = bus.rd && !empty_q;
    do_wr      = bus.wr && (!full_q || bus.rd);
    count_next = count;
    if (do_wr && !do_rd)
      count_next = count + 1'b1;
    else if (!do_wr && do_rd)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == CW'(DEPTH));
      if (bus.wr && full_q && !bus.rd)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.clr && do_wr)
      mem[wr_ptr] <= bus.in;
  end

  assign bus.out   = bus.oe ? (empty_q ? '0 : mem[rd_ptr]) : 'z;
  assign bus.empty = empty_q;
  assign bus.full  = full_q;
  assign bus.ovf   = ovf_q;

`ifdef BUS_FIFO_LEVEL_EN
  assign bus.level = count;
`endif
endmodule

// File: tb/tb_bus_fifo.sv
// tb/tb_bus_fifo.sv - scoreboard bench for bus_fifo
module tb_bus_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bus_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();
  bus_fifo #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  always @(negedge clk) begin
    if (reset_n && bus.rd && bus.oe && !bus.clr) begin
      logic [7:0] e;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL monitor_read: got %h required no read", bus.out);
      end else begin
        e = sb.pop_front();
        if (bus.out !== e) begin
          n_fail++;
          $display("FAIL monitor_read: got %h required %h", bus.out, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic [7:0] exp_out);
    bus.wr  = w;
    bus.rd  = r;
    bus.in  = d;
    bus.clr = 1'b0;
    if (r && bus.oe)
      sb.push_back(exp_out);
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic fill4();
    cyc(1'b1, 1'b0, 8'h11, 8'h00);
    cyc(1'b1, 1'b0, 8'h22, 8'h00);
    cyc(1'b1, 1'b0, 8'h33, 8'h00);
    cyc(1'b1, 1'b0, 8'h44, 8'h00);
  endtask

  initial begin
    bus.clr = 1'b0;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.oe  = 1'b1;
    bus.in  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", {7'd0, bus.empty}, 8'h01);
    chk("reset_full",  {7'd0, bus.full},  8'h00);
    chk("reset_ovf",   {7'd0, bus.ovf},   8'h00);
    chk("reset_out",   bus.out,           8'h00);
    reset_n = 1'b1;

    // order and overflow
    fill4();
    chk("fill_full",  {7'd0, bus.full},  8'h01);
    chk("fill_empty", {7'd0, bus.empty}, 8'h00);
    cyc(1'b1, 1'b0, 8'hAA, 8'h00);
    chk("ovf_set",    {7'd0, bus.ovf},   8'h01);
    chk("ovf_full",   {7'd0, bus.full},  8'h01);
    chk("ovf_head",   bus.out,           8'h11);
    cyc(1'b0, 1'b1, 8'h00, 8'h11);
    cyc(1'b0, 1'b1, 8'h00, 8'h22);
    cyc(1'b0, 1'b1, 8'h00, 8'h33);
    cyc(1'b0, 1'b1, 8'h00, 8'h44);
    chk("drain_empty", {7'd0, bus.empty}, 8'h01);
    chk("drain_out",   bus.out,           8'h00);
    chk("ovf_sticky",  {7'd0, bus.ovf},   8'h01);
    bus.clr = 1'b1;
    bus.wr  = 1'b1;
    bus.in  = 8'hBB;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    bus.wr  = 1'b0;
    chk("clr_ovf",   {7'd0, bus.ovf},   8'h00);
    chk("clr_empty", {7'd0, bus.empty}, 8'h01);
    chk("clr_out",   bus.out,           8'h00);

    // simultaneous on full
    fill4();
    cyc(1'b1, 1'b1, 8'h55, 8'h11);
    chk("rw_full_full", {7'd0, bus.full}, 8'h01);
    chk("rw_full_head", bus.out,          8'h22);
    cyc(1'b0, 1'b1, 8'h00, 8'h22);
    cyc(1'b0, 1'b1, 8'h00, 8'h33);
    cyc(1'b0, 1'b1, 8'h00, 8'h44);
    cyc(1'b0, 1'b1, 8'h00, 8'h55);
    chk("rw_full_drain", {7'd0, bus.empty}, 8'h01);

    // simultaneous on empty: no fall-through
    bus.oe = 1'b0;
    cyc(1'b1, 1'b1, 8'h66, 8'h00);
    bus.oe = 1'b1;
    #1;
    chk("rw_empty_out",   bus.out,           8'h66);
    chk("rw_empty_empty", {7'd0, bus.empty}, 8'h00);
    chk("rw_empty_full",  {7'd0, bus.full},  8'h00);
`ifdef BUS_FIFO_LEVEL_EN
    chk("rw_empty_level", {5'd0, bus.level}, 8'h01);
`endif
    cyc(1'b0, 1'b1, 8'h00, 8'h66);

    // underflow is ignored
    bus.oe = 1'b0;
    cyc(1'b0, 1'b1, 8'h00, 8'h00);
    bus.oe = 1'b1;
    #1;
    chk("udf_empty", {7'd0, bus.empty}, 8'h01);
    chk("udf_ovf",   {7'd0, bus.ovf},   8'h00);
    cyc(1'b1, 1'b0, 8'h77, 8'h00);
    chk("udf_head",  bus.out,           8'h77);
    cyc(1'b0, 1'b1, 8'h00, 8'h77);

`ifdef BUS_FIFO_LEVEL_EN
    chk("level_0", {5'd0, bus.level}, 8'h00);
    cyc(1'b1, 1'b0, 8'hC1, 8'h00);
    chk("level_1", {5'd0, bus.level}, 8'h01);
    cyc(1'b1, 1'b0, 8'hC2, 8'h00);
    chk("level_2", {5'd0, bus.level}, 8'h02);
    cyc(1'b1, 1'b0, 8'hC3, 8'h00);
    chk("level_3", {5'd0, bus.level}, 8'h03);
    cyc(1'b1, 1'b0, 8'hC4, 8'h00);
    chk("level_4", {5'd0, bus.level}, 8'h04);
    cyc(1'b0, 1'b1, 8'h00, 8'hC1);
    chk("level_rd", {5'd0, bus.level}, 8'h03);
    cyc(1'b0, 1'b1, 8'h00, 8'hC2);
    cyc(1'b0, 1'b1, 8'h00, 8'hC3);
    cyc(1'b0, 1'b1, 8'h00, 8'hC4);
`endif

    // pointer wrap
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 8'h00);
      cyc(1'b0, 1'b1, 8'h00, 8'(i));
    end
    chk("wrap_empty", {7'd0, bus.empty}, 8'h01);

    // asynchronous reset mid-operation
    fill4();
    cyc(1'b1, 1'b0, 8'hAA, 8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_empty", {7'd0, bus.empty}, 8'h01);
    chk("areset_full",  {7'd0, bus.full},  8'h00);
    chk("areset_ovf",   {7'd0, bus.ovf},   8'h00);
    chk("areset_out",   bus.out,           8'h00);
    bus.oe = 1'b0;
    #1;
    n_tests++;
    if (bus.out !== 8'bz) begin
      n_fail++;
      $display("FAIL oe_off_z: got %h required zz", bus.out);
    end
    #1;
    reset_n = 1'b1;
    bus.oe  = 1'b1;
    @(posedge clk);
    #1;
    chk("sb_drained", 8'(sb.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
